lane_reorder_merge: RTL and testbench

LANE_REORDER_MERGE -- requirements
Module: lane_reorder_merge

---
 rtl/lane_reorder_merge_pkg.sv | 21 ++
 rtl/lane_reorder_merge_if.sv | 29 ++
 rtl/lane_reorder_merge_lane_fifo.sv | 64 ++++++
 rtl/lane_reorder_merge.sv | 101 ++++++++++
 tb/tb_lane_reorder_merge.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_reorder_merge_pkg.sv
// Shared defaults and helpers for the lane reorder/merge block.
package lane_reorder_merge_pkg;

  localparam int DEF_N_LANES    = 4;
  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  // Ceiling log2, usable in constant expressions for port and counter widths.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lane_reorder_merge_if.sv
// Bundle of the lane merge stream signals; master drives lane results, slave merges them.
interface lane_reorder_merge_if
  import lane_reorder_merge_pkg::*;
#(
  parameter int N_LANES    = DEF_N_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  // Strobe semantics, no backpressure: valid[k] writes lane k's slice at the edge it is
  // high; o_valid is a one-cycle strobe per merged word and o_data/o_lane hold otherwise.
  logic [N_LANES-1:0]            valid;
  logic [N_LANES*DATA_WIDTH-1:0] data;
  logic                          flush;
  logic [DATA_WIDTH-1:0]         o_data;
  logic                          o_valid;
  logic [N_LANES-1:0]            o_overflow;
  logic [clog2(N_LANES)-1:0]     o_lane;

  modport master (
    output valid, data, flush,
    input  o_data, o_valid, o_overflow, o_lane
  );

  modport slave (
    input  valid, data, flush,
    output o_data, o_valid, o_overflow, o_lane
  );

endinterface

// File: rtl/lane_reorder_merge_lane_fifo.sv
// Per-lane synchronous FIFO; head word is visible combinationally, pop only when non-empty.
module lane_fifo
  import lane_reorder_merge_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CW         = clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  always_comb begin
    rd_ok   = rd_en & ~empty & ~flush;
    // A full lane still accepts a write when its head leaves on the same edge.
    wr_ok   = wr_en & ~flush & (~full | rd_ok);
    wptr_d  = wptr_q + AW'(wr_ok);
    rptr_d  = rptr_q + AW'(rd_ok);
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/lane_reorder_merge.sv
// Merges per-lane results back into pixel order: strict round-robin pop from lane FIFOs,
// registered output, sticky per-lane overflow flags.
module lane_reorder_merge
  import lane_reorder_merge_pkg::*;
#(
  parameter int N_LANES    = DEF_N_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic [N_LANES-1:0]            i_VALID,
  input  logic [N_LANES*DATA_WIDTH-1:0] i_DATA,
  input  logic                          i_FLUSH,
  output logic [DATA_WIDTH-1:0]         o_DATA,
  output logic                          o_VALID,
  output logic [N_LANES-1:0]            o_OVERFLOW,
  output logic [clog2(N_LANES)-1:0]     o_LANE
);

  localparam int LW = clog2(N_LANES);
  localparam int CW = clog2(FIFO_DEPTH) + 1;

  logic [N_LANES-1:0]    lane_wr, lane_pop, lane_full, lane_empty;
  logic [DATA_WIDTH-1:0] lane_head  [N_LANES];
  logic [CW-1:0]         lane_count [N_LANES];

  logic [LW-1:0]         sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [N_LANES-1:0]    ovf_q, ovf_d;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lane_wr[k] = i_VALID[k] & ~i_FLUSH;

    lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (i_CLK),
      .rst_n   (i_RSTn),
      .flush   (i_FLUSH),
      .wr_en   (lane_wr[k]),
      .rd_en   (lane_pop[k]),
      .wr_data (i_DATA[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_data (lane_head[k]),
      .full    (lane_full[k]),
      .empty   (lane_empty[k]),
      .count   (lane_count[k])
    );

    a_count_bound: assert property (@(posedge i_CLK) disable iff (!i_RSTn)
      lane_count[k] <= CW'(FIFO_DEPTH));
  end

  always_comb begin
    lane_pop = '0;
    sel_d    = sel_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;
    if (i_FLUSH) begin
      sel_d = '0;
      ovf_d = '0;
    end else begin
      // Strict order: an empty selected lane stalls the merge even if others hold data.
      if (!lane_empty[sel_q]) begin
        lane_pop[sel_q] = 1'b1;
        valid_d         = 1'b1;
        data_d          = lane_head[sel_q];
        lane_d          = sel_q;
        sel_d           = (sel_q == LW'(N_LANES - 1)) ? '0 : sel_q + 1'b1;
      end
      ovf_d = ovf_q | (i_VALID & lane_full & ~lane_pop);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lane_q  <= '0;
      ovf_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_VALID    = valid_q;
  assign o_DATA     = data_q;
  assign o_LANE     = lane_q;
  assign o_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_lane_reorder_merge.sv
// Randomized and directed bench for lane_reorder_merge against a queue-based pixel-order model.
module tb_lane_reorder_merge;
  import lane_reorder_merge_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int LW    = 2;
  localparam int W     = LW + DW;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_reorder_merge_if #(.N_LANES(N), .DATA_WIDTH(DW)) bus ();

  lane_reorder_merge #(
    .N_LANES    (N),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_CLK      (clk),
    .i_RSTn     (rst_n),
    .i_VALID    (bus.valid),
    .i_DATA     (bus.data),
    .i_FLUSH    (bus.flush),
    .o_DATA     (bus.o_data),
    .o_VALID    (bus.o_valid),
    .o_OVERFLOW (bus.o_overflow),
    .o_LANE     (bus.o_lane)
  );

  // reference model: one queue of words waiting, tagged with the lane they arrived on
  typedef struct {
    int            lane;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          pend[$];
  logic [W-1:0]  exp_q[$];
  int            mdl_sel;
  logic [N-1:0]  mdl_ovf;
  logic [DW-1:0] last_data;
  int            last_lane;
  logic          exp_valid;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_occ(input int lane);
    int n;
    n = 0;
    foreach (pend[i]) if (pend[i].lane == lane) n++;
    return n;
  endfunction

  task automatic model_clear();
    pend.delete();
    mdl_sel = 0;
    mdl_ovf = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic f);
    int            idx;
    logic          found;
    logic [DW-1:0] w;
    exp_valid = 1'b0;
    if (f) begin
      model_clear();
    end else begin
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < pend.size(); i++) begin
        if (!found && pend[i].lane == mdl_sel) begin
          found = 1'b1;
          idx   = i;
        end
      end
      if (found) begin
        w = pend[idx].data;
        pend.delete(idx);
        exp_valid = 1'b1;
        exp_q.push_back({LW'(mdl_sel), w});
        last_data = w;
        last_lane = mdl_sel;
        mdl_sel   = (mdl_sel + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
        if (v[k]) begin
          if (lane_occ(k) < DEPTH) pend.push_back('{lane: k, data: d[k*DW +: DW]});
          else mdl_ovf[k] = 1'b1;
        end
      end
    end
  endtask

  // driver: apply one cycle of inputs, then compare every output against the model
  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic f);
    logic [W-1:0] w;
    bus.valid = v;
    bus.data  = d;
    bus.flush = f;
    @(posedge clk);
    #1;
    model_edge(v, d, f);
    bus.valid = '0;
    bus.flush = 1'b0;
    check_eq("o_valid", 64'(bus.o_valid), 64'(exp_valid));
    if (exp_valid) begin
      w = exp_q.pop_front();
      check_eq("o_data", 64'(bus.o_data), 64'(w[DW-1:0]));
      check_eq("o_lane", 64'(bus.o_lane), 64'(w[W-1:DW]));
    end else begin
      check_eq("hold_data", 64'(bus.o_data), 64'(last_data));
      check_eq("hold_lane", 64'(bus.o_lane), 64'(last_lane));
    end
    check_eq("o_overflow", 64'(bus.o_overflow), 64'(mdl_ovf));
  endtask

  function automatic logic [N*DW-1:0] one_data(input int lane, input logic [DW-1:0] val);
    logic [N*DW-1:0] d;
    d = '0;
    d[lane*DW +: DW] = val;
    return d;
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom_range(0, 32'hFF_FFFF));
    return d;
  endfunction

  task automatic send(input int lane, input logic [DW-1:0] val);
    logic [N-1:0] m;
    m       = '0;
    m[lane] = 1'b1;
    step(m, one_data(lane, val), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  task automatic flush_now();
    step('0, '0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(bus.o_valid), 64'(0));
    check_eq({tag, "_data"}, 64'(bus.o_data), 64'(0));
    check_eq({tag, "_lane"}, 64'(bus.o_lane), 64'(0));
    check_eq({tag, "_ovf"}, 64'(bus.o_overflow), 64'(0));
  endtask

  task automatic mid_reset();
    bus.valid = '0;
    bus.flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    exp_q.delete();
    last_data = '0;
    last_lane = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int   tput;
    logic seen_after_rst;

    bus.valid = '0;
    bus.data  = '0;
    bus.flush = 1'b0;
    model_clear();
    last_data = '0;
    last_lane = 0;
    exp_valid = 1'b0;

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // in-order arrival, 1-bit style values
    flush_now();
    send(0, 24'd1);
    send(1, 24'd0);
    send(2, 24'd1);
    send(3, 24'd1);
    idle(4);

    // out-of-order arrival: nothing leaves until lane 0 shows up
    flush_now();
    send(2, 24'hAA0000);
    send(1, 24'h00BB00);
    send(0, 24'h0000CC);
    idle(4);

    // overflow on lane 3 while lane 0 stays empty
    flush_now();
    for (int i = 0; i < 5; i++) send(3, DW'(24'h300 + i));
    check_eq("ovf_lane3", 64'(bus.o_overflow), 64'(4'b1000));
    send(0, 24'h000100);
    send(1, 24'h000101);
    send(2, 24'h000102);
    idle(3);

    // full lane 0 selected: write on the same edge as its pop is kept
    flush_now();
    send(0, 24'd11);
    for (int i = 0; i < 4; i++) send(0, DW'(21 + i));
    send(1, 24'd31);
    send(2, 24'd32);
    send(3, 24'd33);
    idle(1);
    send(0, 24'd25);
    check_eq("ovf_full_same_edge", 64'(bus.o_overflow), 64'(0));
    for (int r = 0; r < 4; r++) begin
      send(1, DW'(40 + r));
      send(2, DW'(50 + r));
      send(3, DW'(60 + r));
      idle(1);
    end
    idle(1);

    // flush with buffered words, SEL parked on 2 and a sticky flag set
    flush_now();
    send(0, 24'h0A0A0A);
    send(1, 24'h0B0B0B);
    idle(1);
    step(4'b1011, rand_data(), 1'b0);
    for (int i = 0; i < 4; i++) send(3, DW'($urandom_range(0, 255)));
    step(4'b1111, rand_data(), 1'b1);
    check_eq("flush_valid", 64'(bus.o_valid), 64'(0));
    check_eq("flush_ovf", 64'(bus.o_overflow), 64'(0));
    send(0, 24'h123456);
    idle(3);

    // round-robin delivery sustains one word per cycle
    flush_now();
    tput = 0;
    for (int i = 0; i < 40; i++) begin
      send(i % N, DW'($urandom_range(0, 32'hFF_FFFF)));
      if (bus.o_valid) tput++;
    end
    check_eq("throughput", 64'(tput), 64'(39));
    idle(3);

    // random stream with a reset mid-way, then a fresh ordered stream
    flush_now();
    seen_after_rst = 1'b0;
    for (int p = 0; p < 100; p++) begin
      if (p == 50) mid_reset();
      step(N'($urandom_range(0, 15)), rand_data(), 1'b0);
      if (p >= 50 && bus.o_valid && !seen_after_rst) begin
        seen_after_rst = 1'b1;
        check_eq("first_lane_after_rst", 64'(bus.o_lane), 64'(0));
      end
    end
    flush_now();
    for (int i = 0; i < 20; i++) send(i % N, DW'($urandom_range(0, 32'hFF_FFFF)));
    idle(3);
    for (int i = 0; i < 30; i++) step(N'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 19) == 0));
    idle(6);

    check_eq("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
